// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Holds the writeback data width, the register-address width, the encodings
// of the 3:1 writeback-mux select, and the round-robin pointer successor helper.
package wb_arbiter_pkg;

   localparam int INST_WIDTH = 32;
   localparam int RD_W       = 5;

   typedef enum logic [1:0] {
      SEL_ALU  = 2'b00,
      SEL_LSU  = 2'b01,
      SEL_MDU  = 2'b10,
      SEL_NONE = 2'b11
   } sel_t;

   // Successor of a source index in the 0,1,2 ring.
   function automatic logic [1:0] rr_next(input logic [1:0] k);
      return (k == 2'd2) ? 2'd0 : k + 2'd1;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the three execution sources (ALU, LSU, MDU) and the
// register-file write port.
//   stall_i            write port unavailable this cycle
//   <src>_valid_i      source holds a writeback
//   <src>_rd_i         destination register of the source
//   <src>_data_i       writeback data of the source
//   <src>_ready_o      source granted this cycle
//   sel_o              writeback-mux select (00 ALU, 01 LSU, 10 MDU, 11 none)
//   wb_we_o/rd_o/data_o registered register-file write port
// The slave modport is the arbiter; the master modport is the pipeline side.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic                  stall_i;
   logic                  alu_valid_i, lsu_valid_i, mdu_valid_i;
   logic [RD_W-1:0]       alu_rd_i, lsu_rd_i, mdu_rd_i;
   logic [INST_WIDTH-1:0] alu_data_i, lsu_data_i, mdu_data_i;
   logic                  alu_ready_o, lsu_ready_o, mdu_ready_o;
   logic [1:0]            sel_o;
   logic                  wb_we_o;
   logic [RD_W-1:0]       wb_rd_o;
   logic [INST_WIDTH-1:0] wb_data_o;

   modport slave (
      input  stall_i,
      input  alu_valid_i, lsu_valid_i, mdu_valid_i,
      input  alu_rd_i, lsu_rd_i, mdu_rd_i,
      input  alu_data_i, lsu_data_i, mdu_data_i,
      output alu_ready_o, lsu_ready_o, mdu_ready_o,
      output sel_o, wb_we_o, wb_rd_o, wb_data_o
   );

   modport master (
      output stall_i,
      output alu_valid_i, lsu_valid_i, mdu_valid_i,
      output alu_rd_i, lsu_rd_i, mdu_rd_i,
      output alu_data_i, lsu_data_i, mdu_data_i,
      input  alu_ready_o, lsu_ready_o, mdu_ready_o,
      input  sel_o, wb_we_o, wb_rd_o, wb_data_o
   );

endinterface

// File: rtl/wb_arbiter_mux3.sv
// Generic 3:1 multiplexer used on the writeback path.
//   sel_i  00 -> d0_i, 01 -> d1_i, 10 -> d2_i, 11 -> all zeros
//   d0_i/d1_i/d2_i  data inputs, W bits
//   y_o    selected data, W bits
module mux3 #(
   parameter int W = 32
) (
   input  logic [1:0]   sel_i,
   input  logic [W-1:0] d0_i,
   input  logic [W-1:0] d1_i,
   input  logic [W-1:0] d2_i,
   output logic [W-1:0] y_o
);

   always_comb begin
      case (sel_i)
         2'b00:   y_o = d0_i;
         2'b01:   y_o = d1_i;
         2'b10:   y_o = d2_i;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/LSU/MDU per cycle for the single
// register-file write port and registers the winning write.
//   RR_EN  1 = round-robin starting at rr_ptr, 0 = fixed priority ALU > LSU > MDU
//   clk_i  sole clock
//   rst_i  synchronous active-high reset
//   bus    writeback bus (slave side): valid/rd/data in, ready/sel out,
//          registered wb_we_o/wb_rd_o/wb_data_o out one cycle after the grant
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   wb_arbiter_if.slave bus
);

   // Bit 3 is a constant zero so an index of 3 can never select a request.
   logic [3:0]            valid;
   logic [1:0]            rr_ptr;
   logic [1:0]            idx;
   sel_t                  sel;
   logic [RD_W-1:0]       mux_rd;
   logic [INST_WIDTH-1:0] mux_data;
   logic                  we_q;
   logic [RD_W-1:0]       rd_q;
   logic [INST_WIDTH-1:0] data_q;

   assign valid = {1'b0, bus.mdu_valid_i, bus.lsu_valid_i, bus.alu_valid_i};

   function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   // Grant decision. The round-robin search runs from the farthest offset
   // down to the nearest so the last hit is the first valid source after rr_ptr.
   always_comb begin
      sel = SEL_NONE;
      idx = 2'd0;
      if (!rst_i && !bus.stall_i) begin
         if (RR_EN) begin
            for (int i = 2; i >= 0; i--) begin
               idx = mod3_add(rr_ptr, 2'(i));
               if (valid[idx]) sel = sel_t'(idx);
            end
         end else if (valid[0]) begin
            sel = SEL_ALU;
         end else if (valid[1]) begin
            sel = SEL_LSU;
         end else if (valid[2]) begin
            sel = SEL_MDU;
         end
      end
   end

   assign bus.sel_o       = sel;
   assign bus.alu_ready_o = (sel == SEL_ALU);
   assign bus.lsu_ready_o = (sel == SEL_LSU);
   assign bus.mdu_ready_o = (sel == SEL_MDU);

   mux3 #(.W(INST_WIDTH)) u_data_mux (
      .sel_i (sel),
      .d0_i  (bus.alu_data_i),
      .d1_i  (bus.lsu_data_i),
      .d2_i  (bus.mdu_data_i),
      .y_o   (mux_data)
   );

   mux3 #(.W(RD_W)) u_rd_mux (
      .sel_i (sel),
      .d0_i  (bus.alu_rd_i),
      .d1_i  (bus.lsu_rd_i),
      .d2_i  (bus.mdu_rd_i),
      .y_o   (mux_rd)
   );

   // Output register. A grant to rd=0 still captures rd/data and advances the
   // pointer, but never writes (x0 is hardwired). Without a grant the address
   // and data hold and only the write enable drops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         rr_ptr <= 2'd0;
      end else if (sel != SEL_NONE) begin
         we_q   <= (mux_rd != '0);
         rd_q   <= mux_rd;
         data_q <= mux_data;
         rr_ptr <= rr_next(sel);
      end else begin
         we_q   <= 1'b0;
      end
   end

   assign bus.wb_we_o   = we_q;
   assign bus.wb_rd_o   = rd_q;
   assign bus.wb_data_o = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: one round-robin and one fixed-priority instance fed
// with identical request streams. Each source is a FIFO of pending writebacks;
// the head is presented with valid held until granted.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   typedef struct packed {
      logic [RD_W-1:0]       rd;
      logic [INST_WIDTH-1:0] data;
   } item_t;

   typedef struct packed {
      logic                  we;
      logic [RD_W-1:0]       rd;
      logic [INST_WIDTH-1:0] data;
   } wb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic  rst   = 1'b1;
   logic  stall = 1'b0;
   logic  vin [2][3];
   item_t din [2][3];
   logic  rdy [2][3];
   logic [1:0] sel [2];
   wb_t   wbo [2];

   wb_arbiter_if bus0 ();
   wb_arbiter_if bus1 ();

   assign bus0.stall_i     = stall;
   assign bus0.alu_valid_i = vin[0][0];
   assign bus0.lsu_valid_i = vin[0][1];
   assign bus0.mdu_valid_i = vin[0][2];
   assign bus0.alu_rd_i    = din[0][0].rd;
   assign bus0.lsu_rd_i    = din[0][1].rd;
   assign bus0.mdu_rd_i    = din[0][2].rd;
   assign bus0.alu_data_i  = din[0][0].data;
   assign bus0.lsu_data_i  = din[0][1].data;
   assign bus0.mdu_data_i  = din[0][2].data;
   assign rdy[0][0] = bus0.alu_ready_o;
   assign rdy[0][1] = bus0.lsu_ready_o;
   assign rdy[0][2] = bus0.mdu_ready_o;
   assign sel[0]    = bus0.sel_o;
   assign wbo[0]    = {bus0.wb_we_o, bus0.wb_rd_o, bus0.wb_data_o};

   assign bus1.stall_i     = stall;
   assign bus1.alu_valid_i = vin[1][0];
   assign bus1.lsu_valid_i = vin[1][1];
   assign bus1.mdu_valid_i = vin[1][2];
   assign bus1.alu_rd_i    = din[1][0].rd;
   assign bus1.lsu_rd_i    = din[1][1].rd;
   assign bus1.mdu_rd_i    = din[1][2].rd;
   assign bus1.alu_data_i  = din[1][0].data;
   assign bus1.lsu_data_i  = din[1][1].data;
   assign bus1.mdu_data_i  = din[1][2].data;
   assign rdy[1][0] = bus1.alu_ready_o;
   assign rdy[1][1] = bus1.lsu_ready_o;
   assign rdy[1][2] = bus1.mdu_ready_o;
   assign sel[1]    = bus1.sel_o;
   assign wbo[1]    = {bus1.wb_we_o, bus1.wb_rd_o, bus1.wb_data_o};

   wb_arbiter #(.RR_EN(1'b1)) dut_rr (.clk_i(clk), .rst_i(rst), .bus(bus0));
   wb_arbiter #(.RR_EN(1'b0)) dut_fp (.clk_i(clk), .rst_i(rst), .bus(bus1));

   // Reference state
   item_t                 src_q [2][3][$];
   wb_t                   exp_q [2][$];
   int                    grant_log [2][$];
   int                    ptr [2];
   logic [RD_W-1:0]       last_rd [2];
   logic [INST_WIDTH-1:0] last_data [2];

   int vectors     = 0;
   int miscompares = 0;

   // First valid source in search order: from p onward (mod 3) for
   // round-robin, from index 0 for fixed priority. 3 means nobody.
   function automatic int ref_grant(input logic [2:0] v, input int p, input bit rr);
      for (int i = 0; i < 3; i++) begin
         int k;
         k = rr ? (p + i) % 3 : i;
         if (v[k]) return k;
      end
      return 3;
   endfunction

   task automatic push_item(input int k, input logic [RD_W-1:0] rd, input logic [INST_WIDTH-1:0] data);
      item_t it;
      it.rd   = rd;
      it.data = data;
      for (int d = 0; d < 2; d++) src_q[d][k].push_back(it);
   endtask

   // One clock cycle: present heads, check the handshake, queue the expected
   // registered writeback for the monitor.
   task automatic step(input logic st, input logic rs);
      logic [2:0] v;
      logic [4:0] exp_hs, act_hs;
      int         g;
      item_t      it;
      wb_t        e;
      @(negedge clk);
      rst   = rs;
      stall = st;
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 3; k++) begin
            vin[d][k] = (src_q[d][k].size() > 0);
            din[d][k] = (src_q[d][k].size() > 0) ? src_q[d][k][0] : '0;
         end
      #1;
      for (int d = 0; d < 2; d++) begin
         v = {vin[d][2], vin[d][1], vin[d][0]};
         g = (rs || st) ? 3 : ref_grant(v, ptr[d], d == 0);
         exp_hs = {g == 2, g == 1, g == 0, 2'(g)};
         act_hs = {rdy[d][2], rdy[d][1], rdy[d][0], sel[d]};
         vectors++;
         if (act_hs !== exp_hs) begin
            miscompares++;
            $display("FAIL handshake dut%0d t=%0t: ready/sel got %b required %b", d, $time, act_hs, exp_hs);
         end
         grant_log[d].push_back(int'(sel[d]));
         if (rs) begin
            ptr[d] = 0;
            last_rd[d] = '0;
            last_data[d] = '0;
            e = '0;
         end else if (g < 3) begin
            it = src_q[d][g].pop_front();
            last_rd[d] = it.rd;
            last_data[d] = it.data;
            e = {it.rd != '0, it.rd, it.data};
            ptr[d] = (g + 1) % 3;
         end else begin
            e = {1'b0, last_rd[d], last_data[d]};
         end
         exp_q[d].push_back(e);
      end
   endtask

   task automatic check_log(input int d, input int exp_l [$], input string name);
      for (int i = 0; i < exp_l.size(); i++) begin
         vectors++;
         if (i >= grant_log[d].size() || grant_log[d][i] != exp_l[i]) begin
            miscompares++;
            $display("FAIL %s dut%0d slot %0d: sel got %0d required %0d", name, d, i,
                     (i < grant_log[d].size()) ? grant_log[d][i] : -1, exp_l[i]);
         end
      end
   endtask

   task automatic clear_logs();
      grant_log[0].delete();
      grant_log[1].delete();
   endtask

   // Monitor: compares the registered write port each cycle against the queue.
   initial begin
      wb_t e;
      forever begin
         @(posedge clk);
         #2;
         for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0) begin
               e = exp_q[d].pop_front();
               vectors++;
               if (wbo[d] !== e) begin
                  miscompares++;
                  $display("FAIL wb_port dut%0d t=%0t: we/rd/data got %b/%0d/%h required %b/%0d/%h",
                           d, $time, wbo[d].we, wbo[d].rd, wbo[d].data, e.we, e.rd, e.data);
               end
            end
         end
      end
   end

   initial begin
      int  el [$];
      int  pending;
      for (int d = 0; d < 2; d++) begin
         ptr[d] = 0;
         last_rd[d] = '0;
         last_data[d] = '0;
         for (int k = 0; k < 3; k++) begin
            vin[d][k] = 1'b0;
            din[d][k] = '0;
         end
      end

      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // Single ALU writeback
      push_item(0, 5'd5, 32'h0000_00AA);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // All sources busy: rotation vs fixed priority
      step(1'b0, 1'b1);
      clear_logs();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 3; k++) push_item(k, 5'(8 + 3 * r + k), $urandom);
      repeat (6) step(1'b0, 1'b0);
      el = '{0, 1, 2, 0, 1, 2};
      check_log(0, el, "rr_order");
      el = '{0, 0, 1, 1, 2, 2};
      check_log(1, el, "fixed_prio");

      // rd=0 transfer advances the pointer without writing
      step(1'b0, 1'b1);
      push_item(1, 5'd0, 32'hDEAD_BEEF);
      clear_logs();
      step(1'b0, 1'b0);
      push_item(0, 5'd1, 32'h1111_1111);
      push_item(2, 5'd2, 32'h2222_2222);
      repeat (3) step(1'b0, 1'b0);
      el = '{1, 2, 0, 3};
      check_log(0, el, "rd0_ptr");

      // Stall mid-stream
      step(1'b0, 1'b1);
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++) push_item(k, 5'(20 + 3 * r + k), $urandom);
      clear_logs();
      repeat (2) step(1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);
      el = '{0, 1, 3, 3, 3, 2, 0, 1, 2, 0, 1, 2, 3};
      check_log(0, el, "stall_resume");

      // Reset right after an MDU transfer
      step(1'b0, 1'b1);
      push_item(2, 5'd7, 32'h7777_0000);
      step(1'b0, 1'b0);
      push_item(0, 5'd3, 32'h3333_3333);
      push_item(1, 5'd4, 32'h4444_4444);
      push_item(2, 5'd6, 32'h6666_6666);
      clear_logs();
      step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      el = '{3, 0, 1, 2, 3};
      check_log(0, el, "post_reset");

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 3; k++)
            if ($urandom_range(0, 3) == 0 && src_q[0][k].size() < 4)
               push_item(k, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
         step($urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
      end

      // Drain
      for (int c = 0; c < 100; c++) begin
         pending = 0;
         for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) pending += src_q[d][k].size();
         if (pending == 0) break;
         step(1'b0, 1'b0);
      end
      pending = 0;
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 3; k++) pending += src_q[d][k].size();
      vectors++;
      if (pending != 0) begin
         miscompares++;
         $display("FAIL drain: pending writebacks got %0d required 0", pending);
      end

      @(posedge clk);
      #3;
      vectors++;
      if (exp_q[0].size() + exp_q[1].size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: leftover entries got %0d required 0",
                  exp_q[0].size() + exp_q[1].size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
